// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch front end.
// Widths here are fixed by the RV32I ISA; address width stays a module parameter.
package fetch_pkg;
    localparam int ILEN       = 32;
    localparam int WORD_BYTES = 4;
    localparam int PC_MAX_W   = 32;

    // Instruction word paired with the address it was fetched from.
    typedef struct packed {
        logic [ILEN-1:0]     data;
        logic [PC_MAX_W-1:0] pc;
    } inst_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO (any DEPTH >= 2); a push becomes visible at the head the next cycle.
// The caller pushes at full only when popping in the same cycle; flush overrides push and pop.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch front end: credit-limited imem requests, in-order responses buffered for decode (>=2 cycles req->inst).
// Decode backpressure throttles requests through queue credits; FETCH_STALL_CNT_EN builds the starvation counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [ILEN-1:0]   imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ILEN-1:0]   inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       stall_cnt
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = ILEN + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_next;
    logic [CW-1:0]     discard;
    logic              credit_ok;
    logic              req_fire;
    logic              resp_fire;
    logic              push;
    logic              pop;
    logic              empty;
    logic [EW-1:0]     head;
    logic              unused_full;
    logic              unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Words already queued plus words still in flight may never exceed the queue.
    assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a memory protocol error and is ignored.
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign push      = resp_fire && (discard == '0) && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !resp_fire) begin
            outstanding_next = outstanding + CW'(1);
        end else if (resp_fire && !req_fire) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    // resp_pc tracks the address of the next non-stale response; responses return in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                discard  <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
                end
                if (push) begin
                    resp_pc <= resp_pc + ADDR_W'(WORD_BYTES);
                end
                if (resp_fire && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({imem_resp_data, resp_pc}),
        .pop       (pop),
        .pop_data  (head),
        .flush     (redirect_valid),
        .count     (count),
        .full      (unused_full),
        .empty     (empty)
    );

    assign inst_valid = !empty;
    assign inst_data  = head[EW-1:ADDR_W];
    assign inst_pc    = head[ADDR_W-1:0];

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!inst_valid && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with programmable latency and a request-order scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid = 1'b0;
    logic [31:0]       imem_resp_data  = '0;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       stall_cnt;

    fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    pend_t       pend_q[$];
    inst_entry_t exp_q[$];
    inst_entry_t dlv_q[$];
    int cycle     = 0;
    int req_fires = 0;
    int mem_lat   = 1;
    int checks    = 0;
    int failures  = 0;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Monitor: requests push expectations, deliveries are recorded, redirect drops undelivered ones.
    always @(posedge clk) begin
        cycle = cycle + 1;
        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            dlv_q.delete();
        end else begin
            if (imem_resp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
            if (redirect_valid) begin
                while (exp_q.size() > dlv_q.size()) void'(exp_q.pop_back());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{addr: imem_req_addr, due: cycle + mem_lat - 1});
                exp_q.push_back('{data: mem_word(imem_req_addr), pc: 32'(imem_req_addr)});
                req_fires++;
            end
            if (inst_valid && inst_ready && !redirect_valid)
                dlv_q.push_back('{data: inst_data, pc: 32'(inst_pc)});
        end
    end

    // Instruction memory: in-order responses, mem_lat cycles after acceptance.
    always @(negedge clk) begin
        if (!rst && pend_q.size() > 0 && pend_q[0].due <= cycle) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 16'h0000) begin failures++; $display("FAIL reset_req_addr got=%h want=0000", imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_inst_data got=%h want=0", inst_data); end
        checks++; if (inst_pc !== 16'h0) begin failures++; $display("FAIL reset_inst_pc got=%h want=0", inst_pc); end
        checks++; if (stall_cnt !== 32'h0) begin failures++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
    endtask

    task automatic test_stream();
        inst_entry_t got, want;
        int base;
        imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        apply_reset();
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL stream_first_req got=%b want=1", imem_req_valid); end
        checks++; if (imem_req_addr !== 16'h0000) begin failures++; $display("FAIL stream_first_addr got=%h want=0000", imem_req_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_c1 got=%b want=0", inst_valid); end
        checks++; if (imem_req_addr !== 16'h0004) begin failures++; $display("FAIL stream_addr_c1 got=%h want=0004", imem_req_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin failures++; $display("FAIL stream_first_inst got valid=%b pc=%h want valid=1 pc=0000", inst_valid, inst_pc); end
        checks++; if (inst_data !== 32'hC0DE_0000) begin failures++; $display("FAIL stream_first_data got=%h want=c0de0000", inst_data); end
        base = dlv_q.size();
        repeat (10) @(negedge clk);
        checks++; if (dlv_q.size() - base != 10) begin failures++; $display("FAIL stream_throughput got=%0d want=10", dlv_q.size() - base); end
        while (dlv_q.size() > 0 && exp_q.size() > 0) begin
            got = dlv_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL stream_entry got pc=%h data=%h want pc=%h data=%h", got.pc, got.data, want.pc, want.data); end
        end
    endtask

    task automatic test_backpressure();
        inst_entry_t got, want;
        int base, ncmp;
        imem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat = 1;
        apply_reset();
        base = req_fires;
        repeat (12) @(negedge clk);
        checks++; if (req_fires - base != DEPTH) begin failures++; $display("FAIL bp_fill_reqs got=%0d want=%0d", req_fires - base, DEPTH); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_full_req_valid got=%b want=0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin failures++; $display("FAIL bp_head got valid=%b pc=%h want valid=1 pc=0000", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (req_fires - base != DEPTH + 1) begin failures++; $display("FAIL bp_pulse_reqs got=%0d want=%0d", req_fires - base, DEPTH + 1); end
        checks++; if (inst_pc !== 16'h0004) begin failures++; $display("FAIL bp_head_after_pulse got=%h want=0004", inst_pc); end
        inst_ready = 1'b1;
        repeat (8) @(negedge clk);
        ncmp = 0;
        while (dlv_q.size() > 0 && exp_q.size() > 0) begin
            got = dlv_q.pop_front(); want = exp_q.pop_front(); ncmp++;
            checks++; if (got !== want) begin failures++; $display("FAIL bp_entry got pc=%h data=%h want pc=%h data=%h", got.pc, got.data, want.pc, want.data); end
        end
        checks++; if (ncmp < 8) begin failures++; $display("FAIL bp_drain_count got=%0d want>=8", ncmp); end
    endtask

    task automatic test_redirect();
        inst_entry_t got, want;
        int base;
        imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 3;
        apply_reset();
        base = req_fires;
        repeat (2) @(negedge clk);
        imem_req_ready = 1'b0;
        checks++; if (req_fires - base != 2) begin failures++; $display("FAIL redir_inflight got=%0d want=2", req_fires - base); end
        redirect_valid = 1'b1; redirect_pc = 16'h0102;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_no_req got=%b want=0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0100) begin failures++; $display("FAIL redir_next_req got valid=%b addr=%h want valid=1 addr=0100", imem_req_valid, imem_req_addr); end
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0100) begin failures++; $display("FAIL redir_first_inst got valid=%b pc=%h want valid=1 pc=0100", inst_valid, inst_pc); end
        checks++; if (inst_data !== 32'hC0DE_0100) begin failures++; $display("FAIL redir_first_data got=%h want=c0de0100", inst_data); end
        repeat (4) @(negedge clk);
        while (dlv_q.size() > 0 && exp_q.size() > 0) begin
            got = dlv_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL redir_entry got pc=%h data=%h want pc=%h data=%h", got.pc, got.data, want.pc, want.data); end
        end
    endtask

    task automatic test_redirect_collision();
        inst_entry_t got, want;
        imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        apply_reset();
        repeat (5) @(negedge clk);
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL coll_pre_valid got=%b want=1", inst_valid); end
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL coll_flushed got=%b want=0", inst_valid); end
        checks++; if (imem_req_addr !== 16'h0200) begin failures++; $display("FAIL coll_req_addr got=%h want=0200", imem_req_addr); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL coll_r1_valid got=%b want=0", inst_valid); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0200) begin failures++; $display("FAIL coll_first_inst got valid=%b pc=%h want valid=1 pc=0200", inst_valid, inst_pc); end
        repeat (3) @(negedge clk);
        while (dlv_q.size() > 0 && exp_q.size() > 0) begin
            got = dlv_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL coll_entry got pc=%h data=%h want pc=%h data=%h", got.pc, got.data, want.pc, want.data); end
        end
    endtask

    task automatic test_wrap();
        inst_entry_t got, want;
        imem_req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 1;
        apply_reset();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_addr !== 16'hFFFC) begin failures++; $display("FAIL wrap_aligned got=%h want=fffc", imem_req_addr); end
        @(negedge clk);
        checks++; if (imem_req_addr !== 16'h0000) begin failures++; $display("FAIL wrap_next got=%h want=0000", imem_req_addr); end
        repeat (4) @(negedge clk);
        while (dlv_q.size() > 0 && exp_q.size() > 0) begin
            got = dlv_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL wrap_entry got pc=%h data=%h want pc=%h data=%h", got.pc, got.data, want.pc, want.data); end
        end
    endtask

    task automatic test_stall_cnt();
        imem_req_ready = 1'b0; inst_ready = 1'b1; mem_lat = 1;
        apply_reset();
        repeat (10) @(negedge clk);
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd10) begin failures++; $display("FAIL stall_starved got=%0d want=10", stall_cnt); end
`else
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL stall_starved got=%0d want=0", stall_cnt); end
`endif
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) @(negedge clk);
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_wait_valid got=%b want=1", inst_valid); end
        @(negedge clk);
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd12) begin failures++; $display("FAIL stall_after_fill got=%0d want=12", stall_cnt); end
`else
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL stall_after_fill got=%0d want=0", stall_cnt); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collision();
        test_wrap();
        test_stall_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
